// File: rtl/uart8_receiver_pkg.sv
// Shared definitions for the 8-bit UART receiver: state encodings,
// default oversample ratio and the 3-sample majority helper.
package uart8_receiver_pkg;

    // 3-bit state encodings shared with the rest of the UART family.
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START_BIT = 3'd2,
        ST_DATA_BITS = 3'd3,
        ST_STOP_BIT  = 3'd4
    } uart_state_t;

    // Default clk ticks per bit period (even, >= 8).
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Two-out-of-three vote used to decide each bit.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart8_receiver_rx_sampler.sv
// Input conditioning for the receiver: 2-flop synchronizer on the raw
// line, a short history of synchronized samples, the majority of the
// current and two previous samples, and a falling-edge flag.
module uart_rx_sampler
    import uart8_receiver_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_rx_async,
    output logic o_majority,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [1:0] r_hist;
    logic       w_rx;

    // The synchronized line is the newest sample; r_hist holds the two
    // before it, so the window {r_hist, w_rx} is the 3-deep sample set.
    assign w_rx = r_sync[1];

    // Synchronize the line and shift the sample history; reset to idle-high
    // so leaving reset can never look like a start-bit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_hist <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx_async};
            r_hist <= {r_hist[0], w_rx};
        end
    end

    assign o_majority = majority3({r_hist, w_rx});
    assign o_fall     = r_hist[0] & ~w_rx;

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver on an oversampled clock. Each bit is decided by a
// majority vote over ticks M-1..M+1 (M = OVERSAMPLE/2), the decision being
// taken at tick M+1. The stop bit is judged half a bit early so that a
// one-stop-bit back-to-back stream and moderate baud mismatch are tolerated.
module uart8_receiver
    import uart8_receiver_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int            TW          = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_DECIDE = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);

    logic          w_majority;
    logic          w_fall;
    logic [TW-1:0] w_tick_next;

    uart_state_t   r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_out;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .reset      (reset),
        .i_rx_async (in),
        .o_majority (w_majority),
        .o_fall     (w_fall)
    );

    // Tick counter runs continuously through a frame, wrapping each bit period.
    assign w_tick_next = (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);

    // Receiver FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (!en) begin
            // Disable parks the FSM; the last byte and err are kept until RESET runs.
            r_state <= ST_RESET;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (w_fall) begin
                        // The edge cycle itself is tick 0 of the start bit.
                        r_tick  <= TW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    r_tick <= w_tick_next;
                    if (r_tick == TICK_DECIDE) begin
                        if (w_majority) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_err   <= 1'b0;
                            r_bit   <= '0;
                            r_state <= ST_DATA_BITS;
                        end
                    end
                end
                ST_DATA_BITS: begin
                    r_tick <= w_tick_next;
                    if (r_tick == TICK_DECIDE) begin
                        r_shift <= {w_majority, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP_BIT;
                        end
                    end
                end
                ST_STOP_BIT: begin
                    r_tick <= w_tick_next;
                    if (r_tick == TICK_DECIDE) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (w_majority) begin
                            r_out  <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
